// File: rtl/btn_repeat.sv
// Per-lane press/auto-repeat event generator with one pending flag per lane, presented lowest index first.
// Event registered on the generating edge; event_ready stalls presentation and a lane that re-fires while still pending drops that event (counted).
module btn_repeat #(
  parameter int N        = 4,
  parameter int DAS_TICK = 20_000_000,
  parameter int ARR_TICK = 5_000_000,
  localparam int IDW     = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [N-1:0]   btn_in,
  input  logic           enable,
  output logic           event_valid,
  output logic [IDW-1:0] event_id,
  input  logic           event_ready,
  output logic [N-1:0]   held,
  output logic [7:0]     drop_cnt
);

  localparam int MAXT = (DAS_TICK > ARR_TICK) ? DAS_TICK : ARR_TICK;
  localparam int CW   = $clog2(MAXT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } lane_state_e;

  lane_state_e   state_q [N];
  lane_state_e   state_d [N];
  logic [CW-1:0] cnt_q   [N];
  logic [CW-1:0] cnt_d   [N];
  logic [N-1:0]  pend_q, pend_d;
  logic [N-1:0]  gen, accept, drop;
  logic [7:0]    drop_q, drop_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
      pend_q <= '0;
      drop_q <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      pend_q <= pend_d;
      drop_q <= drop_d;
    end
  end

  // Lane FSMs: a low button or disabled block always returns the lane to IDLE silently.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      gen[i]     = 1'b0;
      if (!enable || !btn_in[i]) begin
        state_d[i] = IDLE;
        cnt_d[i]   = '0;
      end else begin
        case (state_q[i])
          IDLE: begin
            gen[i]     = 1'b1;
            state_d[i] = DELAY;
            cnt_d[i]   = '0;
          end
          DELAY: begin
            if (cnt_q[i] == CW'(DAS_TICK - 1)) begin
              gen[i]     = 1'b1;
              state_d[i] = REPEAT;
              cnt_d[i]   = '0;
            end else begin
              cnt_d[i] = cnt_q[i] + CW'(1);
            end
          end
          REPEAT: begin
            if (cnt_q[i] == CW'(ARR_TICK - 1)) begin
              gen[i]   = 1'b1;
              cnt_d[i] = '0;
            end else begin
              cnt_d[i] = cnt_q[i] + CW'(1);
            end
          end
          default: begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end
        endcase
      end
    end
  end

  always_comb begin
    event_valid = |pend_q;
    event_id    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pend_q[i]) event_id = IDW'(i);
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      accept[i] = event_valid && event_ready && (event_id == IDW'(i));
      held[i]   = (state_q[i] != IDLE);
    end
  end

  // A lane being accepted on the same edge it re-fires keeps its flag; no drop.
  always_comb begin
    drop   = gen & pend_q & ~accept;
    pend_d = enable ? ((pend_q & ~accept) | gen) : '0;
    drop_d = drop_q;
    for (int i = 0; i < N; i++) begin
      if (drop[i] && (drop_d != 8'hFF)) drop_d = drop_d + 8'd1;
    end
  end

  assign drop_cnt = drop_q;

endmodule

// File: doc/btn_repeat.md
BTN_REPEAT -- requirements
Module: btn_repeat

Interface
REQ-001 SHALL have parameter N, default 4: number of button lanes.
REQ-002 SHALL have parameter DAS_TICK, default 20_000_000: clk cycles from the first event to the first auto-repeat event; legal range >= 2.
REQ-003 SHALL have parameter ARR_TICK, default 5_000_000: clk cycles between auto-repeat events; legal range >= 2.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port btn_in, input, N bits: debounced button levels, 1 = pressed.
REQ-007 SHALL have port enable, input, 1 bit: 0 = block idle and flushed.
REQ-008 SHALL have port event_valid, output, 1 bit: at least one event is pending.
REQ-009 SHALL have port event_id, output, clog2(N) bits: index of the presented event.
REQ-010 SHALL have port event_ready, input, 1 bit: consumer accepts the presented event.
REQ-011 SHALL have port held, output, N bits: lane FSM is not IDLE.
REQ-012 SHALL have port drop_cnt, output, 8 bits: count of events lost to pending overflow, saturating.

Function
REQ-013 SHALL give each lane an FSM with states IDLE, DELAY and REPEAT, plus a tick counter wide enough for max(DAS_TICK, ARR_TICK)-1.
REQ-014 SHALL, in IDLE with btn_in[i]=1, generate an event, enter DELAY and clear the counter.
REQ-015 SHALL, in DELAY, increment the counter; at count DAS_TICK-1 it SHALL generate an event, enter REPEAT and clear the counter.
REQ-016 SHALL, in REPEAT, increment the counter; at count ARR_TICK-1 it SHALL generate an event and clear the counter.
REQ-017 SHALL, when btn_in[i]=0 in any state, enter IDLE with counter 0 without generating an event; already-pending events are kept.
REQ-018 SHALL space events as follows: the first is registered on the edge where btn_in is first sampled high; the next follows DAS_TICK cycles later; each subsequent one follows ARR_TICK cycles after that.
REQ-019 SHALL register a generated event in a 1-bit pending flag per lane.
REQ-020 SHALL drive event_valid = OR of pending and event_id = lowest set pending index; both are combinational from the registered flags.
REQ-021 SHALL clear pending[event_id] on a clock edge with event_valid & event_ready.
REQ-022 SHALL, when the handshake clears lane i on the same edge lane i generates an event, leave pending[i] set, with no drop counted.
REQ-023 SHALL, when lane i generates an event while pending[i]=1 and it is not being accepted, discard the event and increment drop_cnt, saturating at 255.
REQ-024 SHALL ignore event_ready while event_valid=0.
REQ-025 SHALL, with enable=0, force every FSM to IDLE, clear every counter and pending flag, and generate no events; drop_cnt SHALL hold.
REQ-026 SHALL, when enable returns to 1 with a button already high, treat that lane as a fresh press on the first enabled edge.
REQ-027 SHALL keep lanes independent: simultaneous events on several lanes all set their own pending bits on the same edge.

Reset
REQ-028 SHALL, while reset_n=0, immediately force all FSMs to IDLE, counters to 0, pending to 0 and drop_cnt to 0, so that event_valid=0, event_id=0 and held=0.
REQ-029 SHALL, on reset assertion mid-count, discard all in-flight and pending events; after release, a held button counts as a fresh press.

Verification (N=4, DAS_TICK=10, ARR_TICK=4)
REQ-030 SHALL cover: btn_in[1] high for 25 cycles, event_ready=1 -> exactly 5 accepted events with id 1, at relative cycles 0, 10, 14, 18 and 22; held[1] returns to 0 one cycle after release.
REQ-031 SHALL cover: btn_in[0] and btn_in[2] rise on the same edge, event_ready=1 -> id 0 is accepted, then id 2 on the next cycle, with drop_cnt=0.
REQ-032 SHALL cover: btn_in[3] held for 30 cycles, event_ready=0 -> event_valid=1 with id 3, and drop_cnt=5 after 30 cycles; a later single accept then gives event_valid=0.
REQ-033 SHALL cover: the event_ready pulse coincides with the lane-2 auto-repeat edge -> pending[2] stays set, the next cycle presents id 2, and drop_cnt is unchanged.
REQ-034 SHALL cover: enable dropped to 0 for 3 cycles at relative cycle 12 of a lane-1 hold -> pending and held clear; on re-enable a new event follows immediately, then the next one 10 cycles later.
REQ-035 SHALL cover: reset_n pulsed low asynchronously between clock edges while in REPEAT with events pending -> all outputs go to 0 without waiting for a clock edge; after release, the held button restarts the sequence at 0, 10, 14, ...
